// File: rtl/blram_arbiter.sv
// blram_arbiter: burst-bounded round-robin sharing of one single-port blram between two masters
module blram_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32,
    parameter int BURST  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    typedef enum logic [1:0] {NONE, P0, P1} owner_t;
    owner_t     owner, owner_n;
    logic [7:0] cnt, cnt_n;
    logic       last, last_n, pend0, pend1, both, hold;
    always_comb begin
        both      = req0 & req1;
        hold      = (owner != NONE) && (cnt < 8'(BURST));
        gnt0      = rst & ((req0 & ~req1) | (both & (hold ? owner == P0 : last)));
        gnt1      = rst & ((req1 & ~req0) | (both & (hold ? owner == P1 : ~last)));
        owner_n   = gnt0 ? P0 : gnt1 ? P1 : NONE;
        cnt_n     = (owner_n == NONE) ? 8'd0 : (owner_n != owner) ? 8'd1 :
                    (cnt < 8'(BURST)) ? cnt + 8'd1 : cnt;
        last_n    = gnt1 ? 1'b1 : gnt0 ? 1'b0 : last;
        ram_addr  = gnt1 ? addr1 : addr0;
        ram_wdata = gnt1 ? wdata1 : wdata0;
        ram_we    = (gnt0 & we0) | (gnt1 & we1);
        // a read issued just before reset must not surface while reset is held
        rvalid0   = pend0 & rst;
        rvalid1   = pend1 & rst;
        rdata     = ram_rdata;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            owner <= NONE;
            cnt   <= 8'd0;
            last  <= 1'b1;
            pend0 <= 1'b0;
            pend1 <= 1'b0;
        end else begin
            owner <= owner_n;
            cnt   <= cnt_n;
            last  <= last_n;
            pend0 <= gnt0 & ~we0;
            pend1 <= gnt1 & ~we1;
        end
    end
endmodule

// File: tb/tb_blram_arbiter.sv
// tb_blram_arbiter: directed vector table plus hand sequences for contention and reset corners
module tb_blram_arbiter;
    localparam int AW = 14;
    localparam int DW = 32;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic gnt0, gnt1, rvalid0, rvalid1, ram_we;
    logic [DW-1:0] rdata, ram_wdata, ram_rdata;
    logic [AW-1:0] ram_addr;
    logic pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;
    logic [DW-1:0] mem [0:(1<<AW)-1];
    int checks = 0;
    int passed = 0;

    typedef struct {
        logic r0, w0; logic [AW-1:0] a0; logic [DW-1:0] d0;
        logic r1, w1; logic [AW-1:0] a1; logic [DW-1:0] d1;
        logic g0, g1, we; logic [AW-1:0] ra;
        logic v0, v1, rc; logic [DW-1:0] rd;
    } vec_t;
    vec_t tv [15];

    blram_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // blram model: registered read, preload port for test setup
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    initial begin
        //          r0 w0 a0  d0      r1 w1 a1  d1       g0 g1 we ra   v0 v1 rc rd
        tv[0]  = '{1, 0, 600, 0,      0, 0, 0,   0,       1, 0, 0, 600, 0, 0, 0, 0};
        tv[1]  = '{0, 0, 0,   0,      0, 0, 0,   0,       0, 0, 0, 0,   1, 0, 1, 32'h2A};
        tv[2]  = '{0, 0, 0,   0,      1, 1, 515, 32'h1234, 0, 1, 1, 515, 0, 0, 0, 0};
        tv[3]  = '{1, 0, 515, 0,      0, 0, 0,   0,       1, 0, 0, 515, 0, 0, 0, 0};
        tv[4]  = '{0, 0, 0,   0,      0, 0, 0,   0,       0, 0, 0, 0,   1, 0, 1, 32'h1234};
        tv[5]  = '{1, 0, 600, 0,      0, 0, 0,   0,       1, 0, 0, 600, 0, 0, 0, 0};
        tv[6]  = '{0, 0, 0,   0,      1, 1, 700, 32'hBEEF, 0, 1, 1, 700, 1, 0, 1, 32'h2A};
        tv[7]  = '{0, 0, 0,   0,      1, 0, 700, 0,       0, 1, 0, 700, 0, 0, 0, 0};
        tv[8]  = '{1, 0, 515, 0,      0, 0, 0,   0,       1, 0, 0, 515, 0, 1, 1, 32'hBEEF};
        tv[9]  = '{0, 0, 0,   0,      0, 0, 0,   0,       0, 0, 0, 0,   1, 0, 1, 32'h1234};
        tv[10] = '{1, 0, 1,   0,      0, 0, 0,   0,       1, 0, 0, 1,   0, 0, 0, 0};
        tv[11] = '{1, 0, 2,   0,      0, 0, 0,   0,       1, 0, 0, 2,   1, 0, 0, 0};
        tv[12] = '{0, 0, 0,   0,      0, 0, 0,   0,       0, 0, 0, 0,   1, 0, 0, 0};
        tv[13] = '{1, 0, 3,   0,      1, 0, 4,   0,       0, 1, 0, 4,   0, 0, 0, 0};
        tv[14] = '{0, 0, 0,   0,      0, 0, 0,   0,       0, 0, 0, 0,   0, 1, 0, 0};

        req0 = 1'b1; req1 = 1'b1;
        pl_en = 1'b1; pl_addr = 14'd600; pl_data = 32'h2A;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            pl_en = 1'b0;
            #1 check($sformatf("reset%0d {gnt0,gnt1,ram_we,rvalid0,rvalid1}", i),
                     {59'd0, gnt0, gnt1, ram_we, rvalid0, rvalid1}, 64'd0);
        end

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            rst = 1'b1;
            req0 = tv[i].r0; we0 = tv[i].w0; addr0 = tv[i].a0; wdata0 = tv[i].d0;
            req1 = tv[i].r1; we1 = tv[i].w1; addr1 = tv[i].a1; wdata1 = tv[i].d1;
            #1;
            check($sformatf("v%0d gnt0", i), 64'(gnt0), 64'(tv[i].g0));
            check($sformatf("v%0d gnt1", i), 64'(gnt1), 64'(tv[i].g1));
            check($sformatf("v%0d ram_we", i), 64'(ram_we), 64'(tv[i].we));
            check($sformatf("v%0d ram_addr", i), 64'(ram_addr), 64'(tv[i].ra));
            check($sformatf("v%0d rvalid0", i), 64'(rvalid0), 64'(tv[i].v0));
            check($sformatf("v%0d rvalid1", i), 64'(rvalid1), 64'(tv[i].v1));
            if (tv[i].rc) check($sformatf("v%0d rdata", i), 64'(rdata), 64'(tv[i].rd));
        end

        // continuous contention right after reset: runs of four, port 0 first
        @(negedge clk);
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        addr0 = 14'd10; addr1 = 14'd20;
        for (int i = 0; i < 16; i++) begin
            #1;
            check($sformatf("cont%0d gnt0", i), 64'(gnt0), 64'(((i / 4) % 2) == 0));
            check($sformatf("cont%0d gnt1", i), 64'(gnt1), 64'(((i / 4) % 2) == 1));
            check($sformatf("cont%0d rvalid both", i), 64'(rvalid0 & rvalid1), 64'd0);
            @(negedge clk);
        end

        // reset in the cycle after a P1 read grant drops the pending rvalid
        req0 = 1'b0; req1 = 1'b1; addr1 = 14'd515;
        #1 check("rstmid gnt1", 64'(gnt1), 64'd1);
        @(negedge clk);
        rst = 1'b0; req1 = 1'b0;
        #1 check("rstmid rvalid1", 64'(rvalid1), 64'd0);
        check("rstmid gnt1 in reset", 64'(gnt1), 64'd0);
        @(negedge clk);
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1;
        #1 check("post-reset gnt0", 64'(gnt0), 64'd1);
        check("post-reset gnt1", 64'(gnt1), 64'd0);
        check("post-reset rvalid1", 64'(rvalid1), 64'd0);
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
